// File: rtl/seq_rec_sched_pkg.sv
// Shared definitions for the sequence-recorder scheduler: FSM state encoding,
// default recorder register map and the gap timer width.
package seq_rec_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_SIZE0  = 4'd1,
    S_WR_SIZE1  = 4'd2,
    S_WR_START  = 4'd3,
    S_POLL_RD   = 4'd4,
    S_POLL_WAIT = 4'd5,
    S_GAP       = 4'd6,
    S_MEM_RD    = 4'd7,
    S_MEM_WAIT  = 4'd8,
    S_PUSH      = 4'd9,
    S_NEXT      = 4'd10,
    S_FINISH    = 4'd11
  } state_t;

  localparam int DEF_ABUSWIDTH  = 16;
  localparam int DEF_REC_BASE   = 0;
  localparam int DEF_SIZE_OFF   = 3;
  localparam int DEF_START_OFF  = 1;
  localparam int DEF_STATUS_OFF = 2;
  localparam int DEF_MEM_OFF    = 'h1000;
  localparam int DEF_POLL_GAP   = 8;

  // Width of the poll-gap down-counter.
  localparam int TMR_W = 8;

endpackage

// File: rtl/seq_rec_sched_timer.sv
// Loadable down-counter used to space out READY polls; o_zero is high
// whenever the count has reached zero.
module seq_rec_sched_timer
  import seq_rec_sched_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_count;

  // Load has priority; decrement stops at zero so the flag stays stable.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/seq_rec_sched.sv
// Scheduler that programs a sequence recorder over a simple strobe bus,
// polls it for READY, streams the captured bytes to a sink and repeats
// the capture a configurable number of times.
module seq_rec_sched
  import seq_rec_sched_pkg::*;
#(
  parameter int ABUSWIDTH  = DEF_ABUSWIDTH,
  parameter int REC_BASE   = DEF_REC_BASE,
  parameter int SIZE_OFF   = DEF_SIZE_OFF,
  parameter int START_OFF  = DEF_START_OFF,
  parameter int STATUS_OFF = DEF_STATUS_OFF,
  parameter int MEM_OFF    = DEF_MEM_OFF,
  parameter int POLL_GAP   = DEF_POLL_GAP
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 CMD_START,
  input  logic                 CMD_ABORT,
  input  logic [15:0]          CFG_SIZE,
  input  logic [7:0]           CFG_REPEAT,
  output logic [ABUSWIDTH-1:0] M_ADD,
  output logic [7:0]           M_DATA_OUT,
  input  logic [7:0]           M_DATA_IN,
  output logic                 M_WR,
  output logic                 M_RD,
  output logic [7:0]           OUT_DATA,
  output logic                 OUT_WRITE,
  input  logic                 OUT_FULL,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [7:0]           CAP_CNT
);

  localparam logic [ABUSWIDTH-1:0] A_SIZE0  = ABUSWIDTH'(REC_BASE + SIZE_OFF);
  localparam logic [ABUSWIDTH-1:0] A_SIZE1  = ABUSWIDTH'(REC_BASE + SIZE_OFF + 1);
  localparam logic [ABUSWIDTH-1:0] A_START  = ABUSWIDTH'(REC_BASE + START_OFF);
  localparam logic [ABUSWIDTH-1:0] A_STATUS = ABUSWIDTH'(REC_BASE + STATUS_OFF);
  localparam logic [ABUSWIDTH-1:0] A_MEM    = ABUSWIDTH'(REC_BASE + MEM_OFF);
  // The timer counts POLL_GAP-1 down to 0, giving POLL_GAP cycles in GAP.
  localparam logic [TMR_W-1:0]     GAP_LOAD = TMR_W'(POLL_GAP - 1);
  localparam bit                   GAP_EN   = (POLL_GAP != 0);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_size;
  logic [7:0]  r_repeat;
  logic [15:0] r_idx;
  logic [7:0]  r_cap_cnt;
  logic [7:0]  r_out_data;
  logic        r_busy;
  logic        r_abort_pend;

  logic        w_abort;
  logic        w_start;
  logic        w_idx_clr;
  logic        w_idx_inc;
  logic        w_cap_inc;
  logic        w_capture;
  logic        w_tmr_load;
  logic        w_tmr_dec;
  logic        w_tmr_zero;

  // An abort pulse counts immediately and is also remembered until the run ends.
  assign w_abort = r_abort_pend | CMD_ABORT;

  seq_rec_sched_timer u_gap_timer (
    .i_clk      (BUS_CLK),
    .i_srst     (BUS_RST),
    .i_load     (w_tmr_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // State register.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus Moore-style bus strobes; only OUT_WRITE looks at OUT_FULL.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_cap_inc    = 1'b0;
    w_capture    = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_dec    = 1'b0;
    M_ADD        = '0;
    M_DATA_OUT   = '0;
    M_WR         = 1'b0;
    M_RD         = 1'b0;
    OUT_WRITE    = 1'b0;
    DONE         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CMD_START) begin
          w_start      = 1'b1;
          w_next_state = (CFG_SIZE == 16'd0) ? S_FINISH : S_WR_SIZE0;
        end
      end
      S_WR_SIZE0: begin
        M_WR         = 1'b1;
        M_ADD        = A_SIZE0;
        M_DATA_OUT   = r_size[7:0];
        w_next_state = w_abort ? S_FINISH : S_WR_SIZE1;
      end
      S_WR_SIZE1: begin
        M_WR         = 1'b1;
        M_ADD        = A_SIZE1;
        M_DATA_OUT   = r_size[15:8];
        w_next_state = w_abort ? S_FINISH : S_WR_START;
      end
      S_WR_START: begin
        M_WR         = 1'b1;
        M_ADD        = A_START;
        w_next_state = w_abort ? S_FINISH : S_POLL_RD;
      end
      S_POLL_RD: begin
        M_RD         = 1'b1;
        M_ADD        = A_STATUS;
        w_next_state = w_abort ? S_FINISH : S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (w_abort) begin
          w_next_state = S_FINISH;
        end else if (M_DATA_IN[0]) begin
          w_idx_clr    = 1'b1;
          w_next_state = S_MEM_RD;
        end else if (GAP_EN) begin
          w_tmr_load   = 1'b1;
          w_next_state = S_GAP;
        end else begin
          w_next_state = S_POLL_RD;
        end
      end
      S_GAP: begin
        if (w_abort) begin
          w_next_state = S_FINISH;
        end else if (w_tmr_zero) begin
          w_next_state = S_POLL_RD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      // A memory read, once issued, always runs through to its push.
      S_MEM_RD: begin
        M_RD         = 1'b1;
        M_ADD        = A_MEM + ABUSWIDTH'(r_idx);
        w_next_state = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        w_capture    = 1'b1;
        w_next_state = S_PUSH;
      end
      S_PUSH: begin
        if (!OUT_FULL) begin
          OUT_WRITE = 1'b1;
          if (r_idx == (r_size - 16'd1)) begin
            w_next_state = S_NEXT;
          end else if (w_abort) begin
            w_next_state = S_FINISH;
          end else begin
            w_idx_inc    = 1'b1;
            w_next_state = S_MEM_RD;
          end
        end
      end
      S_NEXT: begin
        w_cap_inc = 1'b1;
        // 8-bit compare makes a repeat of 0 match after 256 captures.
        if (w_abort || ((r_cap_cnt + 8'd1) == r_repeat)) begin
          w_next_state = S_FINISH;
        end else begin
          w_next_state = S_WR_START;
        end
      end
      S_FINISH: begin
        DONE         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Run configuration, byte index, capture count and captured byte.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_size     <= '0;
      r_repeat   <= '0;
      r_idx      <= '0;
      r_cap_cnt  <= '0;
      r_out_data <= '0;
    end else begin
      if (w_start) begin
        r_size    <= CFG_SIZE;
        r_repeat  <= CFG_REPEAT;
        r_cap_cnt <= '0;
      end else if (w_cap_inc) begin
        r_cap_cnt <= r_cap_cnt + 8'd1;
      end
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 16'd1;
      end
      if (w_capture) begin
        r_out_data <= M_DATA_IN;
      end
    end
  end

  // BUSY spans the run; abort requests are held until the run finishes.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_busy       <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_start && (CFG_SIZE != 16'd0)) begin
        r_busy <= 1'b1;
      end else if (r_state == S_FINISH) begin
        r_busy <= 1'b0;
      end
      if ((r_state == S_IDLE) || (r_state == S_FINISH)) begin
        r_abort_pend <= 1'b0;
      end else if (CMD_ABORT) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  assign BUSY     = r_busy;
  assign CAP_CNT  = r_cap_cnt;
  assign OUT_DATA = r_out_data;

endmodule
